// File: rtl/calc_if.sv
// Start/done handshake bundle between the calculator controller and the sequential arithmetic core.
interface calc_if #(
  parameter int unsigned WIDTH = 14
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             neg;
  logic             dz;

  modport master (
    output start, op, a, b,
    input  busy, done, result, ovf, neg, dz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, ovf, neg, dz
  );
endinterface

// File: rtl/calc_core_seq.sv
// Multi-cycle add/sub/mul/div core: one-cycle add/sub, shift-add multiply, restoring divide,
// results saturated to MAX_VAL with overflow, negative and divide-by-zero status.
module calc_core_seq #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input logic  clk,
  input logic  rst_n,
  calc_if.slave bus
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0]    MaxWide = DW'(MAX_VAL);
  localparam logic [WIDTH-1:0] MaxRes  = WIDTH'(MAX_VAL);
  localparam logic [CW-1:0]    LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    acc_q;
  logic [DW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] divisor_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             neg_q;
  logic             dz_q;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] mag;
  logic [DW-1:0]    acc_nxt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_low;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quot_nxt;
  logic [DW-1:0]    sat_in;
  logic             sat_ovf;
  logic [WIDTH-1:0] sat_res;
  logic             last_step;

  always_comb begin
    sum_w   = {1'b0, bus.a} + {1'b0, bus.b};
    mag     = (bus.a >= bus.b) ? (bus.a - bus.b) : (bus.b - bus.a);
    acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // A set top bit of the shifted remainder already exceeds any WIDTH-bit divisor.
    rem_sh   = {rem_q, quot_q[WIDTH-1]};
    rem_low  = rem_sh[WIDTH-1:0];
    div_ge   = rem_sh[WIDTH] | (rem_low >= divisor_q);
    rem_nxt  = div_ge ? (rem_low - divisor_q) : rem_low;
    quot_nxt = {quot_q[WIDTH-2:0], div_ge};

    last_step = (cnt_q == LastCnt);

    // One saturation unit shared by every path that enters StDone.
    sat_in = '0;
    case (state_q)
      StMul:   sat_in = acc_nxt;
      StDiv:   sat_in = DW'(quot_nxt);
      default: begin
        case (bus.op)
          2'd0:    sat_in = DW'(sum_w);
          2'd1:    sat_in = DW'(mag);
          default: sat_in = '0;
        endcase
      end
    endcase
    sat_ovf = (sat_in > MaxWide);
    sat_res = sat_ovf ? MaxRes : sat_in[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (bus.op == 2'd2) begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, bus.a};
              mplier_q <= bus.b;
              state_q  <= StMul;
            end else if (bus.op == 2'd3 && bus.b != '0) begin
              rem_q     <= '0;
              quot_q    <= bus.a;
              divisor_q <= bus.b;
              state_q   <= StDiv;
            end else begin
              result_q <= sat_res;
              ovf_q    <= sat_ovf;
              neg_q    <= (bus.op == 2'd1) && (bus.a < bus.b);
              dz_q     <= (bus.op == 2'd3);
              state_q  <= StDone;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last_step) begin
            result_q <= sat_res;
            ovf_q    <= sat_ovf;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDiv: begin
          rem_q  <= rem_nxt;
          quot_q <= quot_nxt;
          cnt_q  <= cnt_q + 1'b1;
          if (last_step) begin
            result_q <= sat_res;
            ovf_q    <= sat_ovf;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.neg    = neg_q;
  assign bus.dz     = dz_q;

endmodule

// File: tb/tb_calc_core_seq.sv
// Randomized bench for calc_core_seq: a behavioural model predicts busy/done timing and
// saturated results from plain arithmetic; directed literals pin the model.
module tb_calc_core_seq;

  localparam int unsigned W    = 14;
  localparam int unsigned MAXV = 9999;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         neg;
    logic         dz;
  } exp_t;

  logic clk;
  logic rst_n;

  calc_if #(.WIDTH(W)) bus ();

  calc_core_seq #(.WIDTH(W), .MAX_VAL(MAXV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t calc(input logic [1:0] o, input longint unsigned x,
                                input longint unsigned y);
    exp_t e;
    longint unsigned v;
    e = '0;
    v = 0;
    case (o)
      2'd0: v = x + y;
      2'd1: begin
        if (x >= y) v = x - y;
        else begin
          v = y - x;
          e.neg = 1'b1;
        end
      end
      2'd2: v = x * y;
      default: begin
        if (y == 0) begin
          v = 0;
          e.dz = 1'b1;
        end else v = x / y;
      end
    endcase
    if (v > MAXV) begin
      e.ovf = 1'b1;
      e.res = W'(MAXV);
    end else e.res = W'(v);
    return e;
  endfunction

  // Model: accepted ops complete L edges later, L = 1 or W+1.
  logic   m_busy, m_done;
  int     m_cnt;
  exp_t   m_out, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_out  <= '0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_out  <= m_pend;
        end
      end else if (bus.start) begin
        m_pend <= calc(bus.op, bus.a, bus.b);
        m_busy <= 1'b1;
        m_cnt  <= (bus.op == 2'd2 || (bus.op == 2'd3 && bus.b != '0)) ? int'(W) + 1 : 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", bus.busy, m_busy);
    chk("done", bus.done, m_done);
    if (!m_busy) begin
      chk("result", bus.result, m_out.res);
      chk("ovf", bus.ovf, m_out.ovf);
      chk("neg", bus.neg, m_out.neg);
      chk("dz", bus.dz, m_out.dz);
    end
    if (bus.done) done_cnt++;
  end

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 120));
      1:       return W'($urandom);
      2:       return W'($urandom_range(9900, 10100));
      default: return W'($urandom_range(0, 3));
    endcase
  endfunction

  // Pulses start for one cycle, scrambles operands, and returns with done high.
  task automatic run_op(input logic [1:0] o, input int unsigned x, input int unsigned y,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = W'(x);
    bus.b     = W'(y);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  task automatic lit(input string name, input int exp_lat, input int lat,
                     input int unsigned exp_res, input logic eo, input logic en, input logic ed);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, bus.result, exp_res);
    chk({name, "_ovf"}, bus.ovf, eo);
    chk({name, "_neg"}, bus.neg, en);
    chk({name, "_dz"}, bus.dz, ed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int snap;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd0, 10, 5, lat);      lit("add", 1, lat, 15, 0, 0, 0);
    run_op(2'd1, 10, 5, lat);      lit("sub_pos", 1, lat, 5, 0, 0, 0);
    run_op(2'd1, 5, 10, lat);      lit("sub_neg", 1, lat, 5, 0, 1, 0);
    run_op(2'd2, 10, 5, lat);      lit("mul", 15, lat, 50, 0, 0, 0);
    run_op(2'd2, 200, 100, lat);   lit("mul_sat", 15, lat, 9999, 1, 0, 0);
    run_op(2'd0, 9999, 1, lat);    lit("add_sat", 1, lat, 9999, 1, 0, 0);
    run_op(2'd3, 10, 5, lat);      lit("div", 15, lat, 2, 0, 0, 0);
    run_op(2'd3, 1, 0, lat);       lit("div_zero", 1, lat, 0, 0, 0, 1);
    run_op(2'd3, 7, 2, lat);       lit("div_odd", 15, lat, 3, 0, 0, 0);
    run_op(2'd3, 16383, 1, lat);   lit("div_sat", 15, lat, 9999, 1, 0, 0);

    // Start pulse during a multiply must be ignored.
    @(negedge clk);
    snap = done_cnt;
    bus.start = 1'b1; bus.op = 2'd2; bus.a = W'(10); bus.b = W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.a = W'(1); bus.b = W'(1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("ignore_done_count", done_cnt - snap, 1);
    chk("ignore_result", bus.result, 50);

    // Reset mid-multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.a = W'(123); bus.b = W'(45);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_ovf", bus.ovf, 0);
    chk("midrst_neg", bus.neg, 0);
    chk("midrst_dz", bus.dz, 0);
    snap = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt - snap, 0);
    run_op(2'd2, 10, 5, lat);      lit("post_rst_mul", 15, lat, 50, 0, 0, 0);

    // Start held high: model tracks accept in every IDLE cycle.
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      bus.start = 1'b1;
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = rand_opnd();
      bus.b     = rand_opnd();
      @(negedge clk);
    end

    // Random traffic with gaps.
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 3) != 0);
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = rand_opnd();
      bus.b     = rand_opnd();
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
